// File: rtl/ctrl_pkg.sv
// Shared types and constants for the I2S APB host: bus ops, phase states,
// default register offsets and status flag positions.
package ctrl_pkg;

   typedef enum logic [1:0] {CFG_WR, STAT_RD, TX_WR, RX_RD} apb_op_t;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

   localparam logic [31:0] CTRL_OFS_DEF = 32'h0;
   localparam logic [31:0] TX_OFS_DEF   = 32'h4;
   localparam logic [31:0] RX_OFS_DEF   = 32'h8;
   localparam logic [31:0] STAT_OFS_DEF = 32'hC;

   // Status register layout: {Tx_full, Tx_empty, Rx_full, Rx_empty}
   localparam int TXF = 3;
   localparam int TXE = 2;
   localparam int RXF = 1;
   localparam int RXE = 0;

endpackage

// File: rtl/apb_req_phase.sv
// Two-cycle APB requester: a start pulse latches the request, then SETUP and
// ACCESS follow with no wait states; a start during ACCESS chains a new transfer.
module apb_req_phase
   import ctrl_pkg::*;
(
   input  logic        pclk,
   input  logic        preset,
   input  logic        start_i,
   input  logic [31:0] addr_i,
   input  logic        write_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] prdata_i,
   output apb_state_t  state_o,
   output logic        access_o,
   output logic [31:0] rdata_o,
   output logic [31:0] paddr_o,
   output logic        pwrite_o,
   output logic        penable_o,
   output logic [31:0] pwdata_o
);

   apb_state_t  state_q, state_d;
   logic [31:0] addr_q, wdata_q;
   logic        write_q;

   // NOTE: sequential state uses non-blocking assignments so every flop sees
   // pre-edge values regardless of process ordering.
   always_ff @(posedge pclk) begin
      if (preset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else if (start_i) begin
         addr_q  <= addr_i;
         write_q <= write_i;
         wdata_q <= wdata_i;
      end
   end

   // NOTE: combinational blocks assign a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  state_d = start_i ? SETUP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      state_o   = state_q;
      access_o  = (state_q == ACCESS);
      penable_o = access_o;
      paddr_o   = (state_q != IDLE) ? addr_q  : '0;
      pwrite_o  = (state_q != IDLE) ? write_q : 1'b0;
      pwdata_o  = (state_q != IDLE) ? wdata_q : '0;
      rdata_o   = access_o ? prdata_i : '0;
   end

endmodule

// File: rtl/i2s_apb_host.sv
// APB host for the I2S transceiver: schedules config writes, status polls,
// Tx writes and Rx reads, and exposes valid/ready streams to the audio side.
module i2s_apb_host
   import ctrl_pkg::*;
#(
   parameter logic [31:0] OFFSET   = 32'h0,
   parameter logic [31:0] CTRL_OFS = CTRL_OFS_DEF,
   parameter logic [31:0] TX_OFS   = TX_OFS_DEF,
   parameter logic [31:0] RX_OFS   = RX_OFS_DEF,
   parameter logic [31:0] STAT_OFS = STAT_OFS_DEF
) (
   input  logic        pclk,
   input  logic        preset,
   input  logic        cfg_valid,
   input  logic [31:0] cfg_word,
   output logic        cfg_ready,
   input  logic        tx_valid,
   input  logic [31:0] tx_data,
   output logic        tx_ready,
   output logic        rx_valid,
   output logic [31:0] rx_data,
   input  logic        rx_ready,
   output logic [31:0] paddr,
   output logic        pwrite,
   output logic        penable,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata
);

   apb_state_t  state_w;
   logic        access_w, start_d, tx_cand, rx_cand;
   logic [31:0] rdata_w, addr_d, wdata_d;
   apb_op_t     op_q, op_d;
   logic        rr_q, rx_valid_q;
   logic [31:0] rx_data_q;

   always_comb begin
      start_d = 1'b0;
      op_d    = op_q;
      tx_cand = tx_valid && !rdata_w[TXF];
      rx_cand = !rdata_w[RXE] && !rx_valid_q;
      case (state_w)
         IDLE: begin
            if (cfg_valid) begin
               start_d = 1'b1;
               op_d    = CFG_WR;
            end else if (tx_valid || !rx_valid_q) begin
               start_d = 1'b1;
               op_d    = STAT_RD;
            end
         end
         ACCESS: begin
            // rr_q set means Tx was served last, so Rx wins a tie
            if (op_q == STAT_RD) begin
               if (tx_cand && (!rx_cand || !rr_q)) begin
                  start_d = 1'b1;
                  op_d    = TX_WR;
               end else if (rx_cand) begin
                  start_d = 1'b1;
                  op_d    = RX_RD;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      addr_d  = OFFSET + STAT_OFS;
      wdata_d = '0;
      case (op_d)
         CFG_WR:  begin addr_d = OFFSET + CTRL_OFS; wdata_d = cfg_word; end
         TX_WR:   begin addr_d = OFFSET + TX_OFS;   wdata_d = tx_data;  end
         RX_RD:   addr_d = OFFSET + RX_OFS;
         default: addr_d = OFFSET + STAT_OFS;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         op_q       <= CFG_WR;
         rr_q       <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         if (start_d) op_q <= op_d;
         if (start_d && state_w == ACCESS) rr_q <= (op_d == TX_WR);
         if (access_w && op_q == RX_RD) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= rdata_w;
         end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   // Ready pulses are suppressed while reset is pending so an abandoned write consumes nothing
   always_comb begin
      cfg_ready = access_w && (op_q == CFG_WR) && !preset;
      tx_ready  = access_w && (op_q == TX_WR)  && !preset;
      rx_valid  = rx_valid_q;
      rx_data   = rx_data_q;
   end

   apb_req_phase u_phase (
      .pclk      (pclk),
      .preset    (preset),
      .start_i   (start_d),
      .addr_i    (addr_d),
      .write_i   ((op_d == CFG_WR) || (op_d == TX_WR)),
      .wdata_i   (wdata_d),
      .prdata_i  (prdata),
      .state_o   (state_w),
      .access_o  (access_w),
      .rdata_o   (rdata_w),
      .paddr_o   (paddr),
      .pwrite_o  (pwrite),
      .penable_o (penable),
      .pwdata_o  (pwdata)
   );

endmodule

// File: tb/tb_i2s_apb_host.sv
// Directed bench for i2s_apb_host: a per-cycle vector table plus sequences for
// Tx withdrawal during a status read and sustained Tx throughput.
module tb_i2s_apb_host;

   localparam logic [31:0] BASE   = 32'h4000_0000;
   localparam logic [31:0] A_CTRL = BASE;
   localparam logic [31:0] A_TX   = BASE + 32'h4;
   localparam logic [31:0] A_RX   = BASE + 32'h8;
   localparam logic [31:0] A_ST   = BASE + 32'hC;
   localparam logic [31:0] T1 = 32'h1234_5678, T2 = 32'hCAFE_0001;
   localparam logic [31:0] T3 = 32'h0000_1111, T4 = 32'h0000_2222;
   localparam logic [31:0] DB = 32'hDEAD_BEEF, R2 = 32'h0000_5A5A;

   logic        pclk = 1'b0;
   logic        preset, cfg_valid, tx_valid, rx_ready;
   logic [31:0] cfg_word, tx_data, prdata;
   logic        cfg_ready, tx_ready, rx_valid, pwrite, penable;
   logic [31:0] rx_data, paddr, pwdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 pclk = ~pclk;

   i2s_apb_host #(.OFFSET(BASE)) dut (
      .pclk(pclk), .preset(preset),
      .cfg_valid(cfg_valid), .cfg_word(cfg_word), .cfg_ready(cfg_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .paddr(paddr), .pwrite(pwrite), .penable(penable), .pwdata(pwdata),
      .prdata(prdata)
   );

   typedef struct {
      logic        p, cv;  logic [31:0] cw;
      logic        tv;     logic [31:0] td;
      logic        rr;     logic [31:0] prd;
      logic [31:0] ea;     logic ew, ee;   logic [31:0] ewd;
      logic        ecr, etr, erv;           logic [31:0] erd;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic p, cv, input logic [31:0] cw,
                               input logic tv, input logic [31:0] td,
                               input logic rr, input logic [31:0] prd,
                               input logic [31:0] ea, input logic ew, ee,
                               input logic [31:0] ewd, input logic ecr, etr, erv,
                               input logic [31:0] erd);
      vec_t v;
      v.p = p; v.cv = cv; v.cw = cw; v.tv = tv; v.td = td; v.rr = rr; v.prd = prd;
      v.ea = ea; v.ew = ew; v.ee = ee; v.ewd = ewd;
      v.ecr = ecr; v.etr = etr; v.erv = erv; v.erd = erd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      preset = v.p; cfg_valid = v.cv; cfg_word = v.cw;
      tx_valid = v.tv; tx_data = v.td; rx_ready = v.rr; prdata = v.prd;
   endtask

   task automatic next_cycle;
      @(posedge pclk);
      #2;
   endtask

   task automatic do_reset;
      preset = 1'b1; cfg_valid = 0; cfg_word = 0; tx_valid = 0; tx_data = 0;
      rx_ready = 0; prdata = 0;
      repeat (2) next_cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rdy_cnt, first_rdy, tx_addr_cnt;
      bit found;

      do_reset();

      // Reset state, then config write
      vq.push_back(mk(1,0,0,      0,0, 0,0, 0,0,0,0,          0,0,0,0));
      vq.push_back(mk(0,1,32'hA5, 0,0, 0,0, 0,0,0,0,          0,0,0,0));
      vq.push_back(mk(0,1,32'hA5, 0,0, 0,0, A_CTRL,1,0,32'hA5, 0,0,0,0));
      vq.push_back(mk(0,1,32'hA5, 0,0, 0,0, A_CTRL,1,1,32'hA5, 1,0,0,0));
      // Status 0101 -> Tx write, tx_ready in cycle 4
      vq.push_back(mk(0,0,0, 1,T1, 0,0,     0,0,0,0,     0,0,0,0));
      vq.push_back(mk(0,0,0, 1,T1, 0,0,     A_ST,0,0,0,  0,0,0,0));
      vq.push_back(mk(0,0,0, 1,T1, 0,32'h5, A_ST,0,1,0,  0,0,0,0));
      vq.push_back(mk(0,0,0, 1,T1, 0,0,     A_TX,1,0,T1, 0,0,0,0));
      vq.push_back(mk(0,0,0, 1,T1, 0,0,     A_TX,1,1,T1, 0,1,0,0));
      // Tx full twice: status polled every 3 cycles, then not full
      for (int k = 0; k < 3; k++) begin
         vq.push_back(mk(0,0,0, 1,T2, 0,0, 0,0,0,0,    0,0,0,0));
         vq.push_back(mk(0,0,0, 1,T2, 0,0, A_ST,0,0,0, 0,0,0,0));
         vq.push_back(mk(0,0,0, 1,T2, 0,(k < 2) ? 32'h9 : 32'h5, A_ST,0,1,0, 0,0,0,0));
      end
      vq.push_back(mk(0,0,0, 1,T2, 0,0, A_TX,1,0,T2, 0,0,0,0));
      vq.push_back(mk(0,0,0, 1,T2, 0,0, A_TX,1,1,T2, 0,1,0,0));
      // Rx read held while rx_ready low
      vq.push_back(mk(0,0,0, 0,0, 0,0,     0,0,0,0,    0,0,0,0));
      vq.push_back(mk(0,0,0, 0,0, 0,0,     A_ST,0,0,0, 0,0,0,0));
      vq.push_back(mk(0,0,0, 0,0, 0,32'h4, A_ST,0,1,0, 0,0,0,0));
      vq.push_back(mk(0,0,0, 0,0, 0,0,     A_RX,0,0,0, 0,0,0,0));
      vq.push_back(mk(0,0,0, 0,0, 0,DB,    A_RX,0,1,0, 0,0,0,0));
      for (int k = 0; k < 3; k++)
         vq.push_back(mk(0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,1,DB));
      vq.push_back(mk(0,0,0, 0,0, 1,0, 0,0,0,0, 0,0,1,DB));
      // Both eligible: Tx first, Rx next
      vq.push_back(mk(0,0,0, 1,T3, 0,0, 0,0,0,0,    0,0,0,DB));
      vq.push_back(mk(0,0,0, 1,T3, 0,0, A_ST,0,0,0, 0,0,0,DB));
      vq.push_back(mk(0,0,0, 1,T3, 0,0, A_ST,0,1,0, 0,0,0,DB));
      vq.push_back(mk(0,0,0, 1,T3, 0,0, A_TX,1,0,T3, 0,0,0,DB));
      vq.push_back(mk(0,0,0, 1,T3, 0,0, A_TX,1,1,T3, 0,1,0,DB));
      vq.push_back(mk(0,0,0, 1,T4, 0,0,  0,0,0,0,    0,0,0,DB));
      vq.push_back(mk(0,0,0, 1,T4, 0,0,  A_ST,0,0,0, 0,0,0,DB));
      vq.push_back(mk(0,0,0, 1,T4, 0,0,  A_ST,0,1,0, 0,0,0,DB));
      vq.push_back(mk(0,0,0, 1,T4, 0,0,  A_RX,0,0,0, 0,0,0,DB));
      vq.push_back(mk(0,0,0, 1,T4, 0,R2, A_RX,0,1,0, 0,0,0,DB));
      // Tx pending bypasses the held Rx sample; reset in the Tx access cycle
      vq.push_back(mk(0,0,0, 1,T4, 0,0, 0,0,0,0,     0,0,1,R2));
      vq.push_back(mk(0,0,0, 1,T4, 0,0, A_ST,0,0,0,  0,0,1,R2));
      vq.push_back(mk(0,0,0, 1,T4, 0,0, A_ST,0,1,0,  0,0,1,R2));
      vq.push_back(mk(0,0,0, 1,T4, 0,0, A_TX,1,0,T4, 0,0,1,R2));
      vq.push_back(mk(1,0,0, 1,T4, 0,0, A_TX,1,1,T4, 0,0,1,R2));
      vq.push_back(mk(0,0,0, 0,0,  0,0, 0,0,0,0,     0,0,0,0));
      vq.push_back(mk(0,0,0, 0,0,  0,0, A_ST,0,0,0,  0,0,0,0));

      foreach (vq[i]) begin
         next_cycle();
         drive(vq[i]);
         #2;
         check($sformatf("row%0d paddr", i),     paddr,     vq[i].ea);
         check($sformatf("row%0d pwrite", i),    32'(pwrite),    32'(vq[i].ew));
         check($sformatf("row%0d penable", i),   32'(penable),   32'(vq[i].ee));
         check($sformatf("row%0d pwdata", i),    pwdata,    vq[i].ewd);
         check($sformatf("row%0d cfg_ready", i), 32'(cfg_ready), 32'(vq[i].ecr));
         check($sformatf("row%0d tx_ready", i),  32'(tx_ready),  32'(vq[i].etr));
         check($sformatf("row%0d rx_valid", i),  32'(rx_valid),  32'(vq[i].erv));
         check($sformatf("row%0d rx_data", i),   rx_data,   vq[i].erd);
      end

      // Tx source withdraws during the status access: no Tx write follows
      do_reset();
      preset = 1'b0; tx_valid = 1'b1; tx_data = 32'h0000_7777; prdata = 32'h5;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         next_cycle();
         if (penable && paddr == A_ST) found = 1'b1;
      end
      check("withdraw stat access reached", 32'(found), 32'd1);
      tx_valid = 1'b0;
      rdy_cnt = 0; tx_addr_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         if (tx_ready) rdy_cnt++;
         if (paddr == A_TX) tx_addr_cnt++;
      end
      check("withdraw tx_ready pulses", 32'(rdy_cnt), 32'd0);
      check("withdraw tx address cycles", 32'(tx_addr_cnt), 32'd0);

      // Sustained Tx: one sample per 5 cycles, first ready in cycle 4
      do_reset();
      preset = 1'b0; tx_valid = 1'b1; tx_data = 32'h0000_3333; prdata = 32'h5;
      rdy_cnt = 0; first_rdy = -1;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) next_cycle();
         #1;
         if (tx_ready) begin
            rdy_cnt++;
            if (first_rdy < 0) first_rdy = c;
         end
      end
      check("throughput tx_ready count", 32'(rdy_cnt), 32'd4);
      check("throughput first tx_ready cycle", 32'(first_rdy), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2s_apb_host.md
# i2s_apb_host

APB requester that drives the I2S transceiver register file from the host side of the APB bus. It accepts a configuration word and a stream of Tx samples on valid/ready ports, writes them into the transceiver over APB, polls the status flags, and drains received samples back out. It sits between a DMA or audio source/sink and `I2S_top`, replacing CPU-driven register access.

## Interface
Parameters:
- `OFFSET`, 0: APB base address of the transceiver; all register addresses are `OFFSET` plus a register offset.
- `CTRL_OFS`, 32'h0: control register offset.
- `TX_OFS`, 32'h4: Tx data register offset.
- `RX_OFS`, 32'h8: Rx data register offset.
- `STAT_OFS`, 32'hC: status register offset; `prdata[3:0]` = {Tx_full, Tx_empty, Rx_full, Rx_empty}.

Ports:
- `pclk` in 1: single clock, also the APB clock.
- `preset` in 1: reset, synchronous, active-high.
- `cfg_valid` in 1, `cfg_word` in 32, `cfg_ready` out 1: control-word handshake.
- `tx_valid` in 1, `tx_data` in 32, `tx_ready` out 1: Tx sample handshake.
- `rx_valid` out 1, `rx_data` out 32, `rx_ready` in 1: Rx sample handshake.
- `paddr` out 32, `pwrite` out 1, `penable` out 1, `pwdata` out 32: APB request.
- `prdata` in 32: APB read data, sampled at the end of the access cycle.

## Operation
- APB transfers take exactly 2 cycles with no wait states:
  - Setup: `penable`=0; `paddr`, `pwrite`, `pwdata` valid.
  - Access: `penable`=1; the same values are held.
- Idle bus: `paddr`=0, `pwrite`=0, `penable`=0, `pwdata`=0.
- FSM states: IDLE, SETUP, ACCESS. An op register holds one of CFG_WR, STAT_RD, TX_WR, RX_RD.
- IDLE selects the next op, in priority order:
  - `cfg_valid` → CFG_WR.
  - Otherwise, `tx_valid`, or Rx buffer empty (`rx_valid`=0) → STAT_RD.
  - Otherwise stay in IDLE.
- End of STAT_RD access, using the captured `prdata[3:0]`:
  - TX candidate: `tx_valid` && !Tx_full.
  - RX candidate: !Rx_empty && `rx_valid`=0.
  - Both candidates: a round-robin bit picks the op not served last; the bit resets to favour TX.
  - Chosen op goes straight to SETUP with no IDLE cycle. No candidate → IDLE.
- CFG_WR, TX_WR and RX_RD always return to IDLE. Each data transfer is therefore preceded by a fresh status read.
- `cfg_ready` and `tx_ready` pulse high for 1 cycle during the access cycle of their write. The input is consumed on that edge.
- RX_RD: `prdata` is captured into `rx_data` at the end of access, and `rx_valid` is set the next cycle. `rx_data` and `rx_valid` are held until `rx_valid && rx_ready`, which clears `rx_valid`.
- Source de-asserting `tx_valid` during STAT_RD: no TX_WR is issued.
- Reset values: all APB outputs 0, `cfg_ready`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, FSM in IDLE.

## Timing
- Tx path, with cycle 0 = IDLE sampling `tx_valid` (not full):
  - STAT setup cycle 1, STAT access cycle 2.
  - TX setup cycle 3, TX access cycle 4, `tx_ready`=1 in cycle 4.
  - Back in IDLE in cycle 5.
- Sustained Tx throughput: 1 sample per 5 cycles.
- Rx path: RX access ends at cycle 4 and `rx_valid` rises in cycle 5. A new STAT_RD cannot start until `rx_valid` is cleared, unless Tx work is pending.
- Config: `cfg_valid` seen in IDLE cycle 0 gives setup in cycle 1, access in cycle 2, `cfg_ready` in cycle 2.
- `preset` mid-transfer: the next edge forces reset values. The transfer is abandoned, no ready pulse is issued, and the held Rx sample is discarded.

## Structure
- Shared package (`ctrl_pkg`):
  - `apb_op_t` enum {CFG_WR, STAT_RD, TX_WR, RX_RD}.
  - `apb_state_t` enum {IDLE, SETUP, ACCESS}.
  - Default register offset constants.
  - Flag bit positions: TXF=3, TXE=2, RXF=1, RXE=0.
- One sub-module, `apb_req_phase`:
  - Takes a start pulse, op address, write flag and data.
  - Drives the setup/access phases.
  - Returns an `access` strobe and captured read data.
- Scheduler and handshakes live in the top.

## Test plan
- Reset, then `cfg_valid`=1 with `cfg_word`=32'h0000_00A5 → cycle 1 `paddr`=OFFSET+0, `pwrite`=1, `penable`=0; cycle 2 `penable`=1, `pwdata`=32'hA5, `cfg_ready`=1.
- `tx_valid`=1, `tx_data`=32'h1234_5678, status returns 4'b0101 → STAT read at +0xC, then write of 32'h1234_5678 at +0x4; `tx_ready` in cycle 4.
- Status 4'b1001 (Tx full) with `tx_valid`=1 → no TX_WR; STAT_RD repeats every 3 cycles until the status shows not full.
- Status 4'b0100 with `prdata` on the Rx read = 32'hDEAD_BEEF and `rx_ready`=0 → `rx_valid`=1, `rx_data`=32'hDEADBEEF held; no further RX_RD until `rx_ready`=1.
- Both Tx and Rx eligible on consecutive status reads → TX_WR first, RX_RD next (round-robin).
- `preset` asserted in the TX access cycle → next cycle all outputs 0, no `tx_ready` pulse, FSM in IDLE.
